// File: rtl/prompt_sequencer.sv
// rtl/prompt_sequencer.sv - quiz round sequencer: one-hot prompt enables, grading, score and frame timeout
module prompt_sequencer #(
    parameter int NUM_Q          = 4,
    parameter int ANS_W          = 8,
    parameter int TIMEOUT_FRAMES = 600,
    localparam int QW = (NUM_Q > 1) ? $clog2(NUM_Q) : 1,
    localparam int SW = $clog2(NUM_Q + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   vsync_tick,
    input  logic                   answer_valid,
    input  logic [ANS_W-1:0]       answer,
    input  logic [NUM_Q*ANS_W-1:0] key_flat,
    output logic [NUM_Q-1:0]       q_en,
    output logic [QW-1:0]          q_idx,
    output logic [SW-1:0]          score,
    output logic                   result_valid,
    output logic                   result_correct,
    output logic                   timed_out,
    output logic                   done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SHOW,
        S_SWITCH,
        S_DONE
    } state_t;

    localparam logic [15:0]   TO_LAST = 16'(TIMEOUT_FRAMES - 1);
    localparam logic [QW-1:0] Q_LAST  = QW'(NUM_Q - 1);
    localparam logic [SW-1:0] S_MAX   = SW'(NUM_Q);

    state_t             state, state_n;
    logic [15:0]        frame_cnt, frame_cnt_n;
    logic [NUM_Q-1:0]   q_en_n;
    logic [QW-1:0]      q_idx_n;
    logic [SW-1:0]      score_n;
    logic               result_valid_n;
    logic               result_correct_n;
    logic               timed_out_n;
    logic [ANS_W-1:0]   key_cur;
    logic               answer_hit;
    logic               timeout_hit;
    logic               last_q;

    function automatic logic [NUM_Q-1:0] one_hot(input logic [QW-1:0] idx);
        logic [NUM_Q-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign key_cur     = key_flat[int'(q_idx) * ANS_W +: ANS_W];
    assign answer_hit  = (answer == key_cur);
    assign last_q      = (q_idx == Q_LAST);
    // An answer arriving on the timeout frame takes priority over the timeout.
    assign timeout_hit = vsync_tick && !answer_valid && (frame_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            frame_cnt      <= '0;
            q_en           <= '0;
            q_idx          <= '0;
            score          <= '0;
            result_valid   <= 1'b0;
            result_correct <= 1'b0;
            timed_out      <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_n;
            frame_cnt      <= frame_cnt_n;
            q_en           <= q_en_n;
            q_idx          <= q_idx_n;
            score          <= score_n;
            result_valid   <= result_valid_n;
            result_correct <= result_correct_n;
            timed_out      <= timed_out_n;
            done           <= (state_n == S_DONE);
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (start) state_n = S_ARM;
            S_ARM:    if (vsync_tick) state_n = S_SHOW;
            S_SHOW:   if (answer_valid || timeout_hit) state_n = S_SWITCH;
            S_SWITCH: if (vsync_tick) state_n = last_q ? S_DONE : S_SHOW;
            S_DONE:   if (start) state_n = S_ARM;
            default:  state_n = S_IDLE;
        endcase
    end

    always_comb begin
        q_en_n           = q_en;
        q_idx_n          = q_idx;
        score_n          = score;
        frame_cnt_n      = frame_cnt;
        result_valid_n   = 1'b0;
        result_correct_n = 1'b0;
        timed_out_n      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                q_en_n = '0;
                if (start) begin
                    q_idx_n = '0;
                    score_n = '0;
                end
            end
            S_ARM: begin
                q_en_n = '0;
                if (vsync_tick) begin
                    q_en_n      = one_hot(q_idx);
                    frame_cnt_n = '0;
                end
            end
            S_SHOW: begin
                if (answer_valid) begin
                    result_valid_n   = 1'b1;
                    result_correct_n = answer_hit;
                    if (answer_hit && score != S_MAX)
                        score_n = score + SW'(1);
                end else if (vsync_tick) begin
                    frame_cnt_n = frame_cnt + 16'd1;
                    if (timeout_hit) begin
                        result_valid_n = 1'b1;
                        timed_out_n    = 1'b1;
                    end
                end
            end
            S_SWITCH: begin
                // The visible prompt only changes on vertical blank.
                if (vsync_tick) begin
                    if (last_q) begin
                        q_en_n = '0;
                    end else begin
                        q_idx_n     = q_idx + QW'(1);
                        q_en_n      = one_hot(q_idx + QW'(1));
                        frame_cnt_n = '0;
                    end
                end
            end
            default: q_en_n = '0;
        endcase
    end

endmodule

// File: tb/tb_prompt_sequencer.sv
// tb/tb_prompt_sequencer.sv - randomized and directed self-checking bench for prompt_sequencer
module tb_prompt_sequencer;
    localparam int NQ = 4;
    localparam int AW = 8;
    localparam int TO = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic            vsync_tick = 1'b0;
    logic            answer_valid = 1'b0;
    logic [AW-1:0]   answer = '0;
    logic [NQ*AW-1:0] key_flat = '0;
    logic [NQ-1:0]   q_en;
    logic [1:0]      q_idx;
    logic [2:0]      score;
    logic            result_valid, result_correct, timed_out, done;

    prompt_sequencer #(.NUM_Q(NQ), .ANS_W(AW), .TIMEOUT_FRAMES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vsync_tick(vsync_tick),
        .answer_valid(answer_valid), .answer(answer), .key_flat(key_flat),
        .q_en(q_en), .q_idx(q_idx), .score(score), .result_valid(result_valid),
        .result_correct(result_correct), .timed_out(timed_out), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Round model: flags describe what the player sees, not controller states.
    bit          m_idle, m_armed, m_open, m_shown, m_done;
    int          m_q, m_score, m_frames;
    bit          e_rv, e_rc, e_to;
    logic [7:0]  mk [NQ];

    task automatic load_keys();
        for (int i = 0; i < NQ; i++) key_flat[i*AW +: AW] = mk[i];
    endtask

    task automatic model_reset();
        m_idle = 1; m_armed = 0; m_open = 0; m_shown = 0; m_done = 0;
        m_q = 0; m_score = 0; m_frames = 0;
        e_rv = 0; e_rc = 0; e_to = 0;
    endtask

    task automatic model_step(input bit st, input bit vs, input bit av, input logic [7:0] ans);
        e_rv = 0; e_rc = 0; e_to = 0;
        if ((m_idle || m_done) && st) begin
            m_idle = 0; m_done = 0; m_armed = 1; m_q = 0; m_score = 0;
        end else if (m_armed) begin
            if (vs) begin
                m_armed = 0; m_shown = 1; m_open = 1; m_frames = 0;
            end
        end else if (m_open) begin
            if (av) begin
                m_open = 0; e_rv = 1; e_rc = (ans == mk[m_q]);
                if (e_rc) m_score++;
            end else if (vs) begin
                if (m_frames == TO - 1) begin
                    m_open = 0; e_rv = 1; e_to = 1;
                end
                m_frames++;
            end
        end else if (m_shown && vs) begin
            if (m_q == NQ - 1) begin
                m_shown = 0; m_done = 1;
            end else begin
                m_q++; m_open = 1; m_frames = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("q_en", 32'(q_en), m_shown ? (32'd1 << m_q) : 32'd0);
        chk("q_idx", 32'(q_idx), 32'(m_q));
        chk("score", 32'(score), 32'(m_score));
        chk("result_valid", 32'(result_valid), 32'(e_rv));
        if (e_rv) chk("result_correct", 32'(result_correct), 32'(e_rc));
        chk("timed_out", 32'(timed_out), 32'(e_to));
        chk("done", 32'(done), 32'(m_done));
    endtask

    task automatic step(input bit st, input bit vs, input bit av, input logic [7:0] ans);
        start = st; vsync_tick = vs; answer_valid = av; answer = ans;
        @(posedge clk);
        model_step(st, vs, av, ans);
        #1;
        check_all();
        start = 0; vsync_tick = 0; answer_valid = 0;
    endtask

    task automatic async_reset();
        #1 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        mk[0] = 8'hA4; mk[1] = 8'h3C; mk[2] = 8'h11; mk[3] = 8'hFF;
        load_keys();
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // all correct
        step(1, 0, 0, 0);
        for (int i = 0; i < NQ; i++) begin
            step(0, 1, 0, 0);
            step(0, 0, 0, 0);
            step(0, 1, 0, 0);
            step(0, 0, 1, mk[i]);
        end
        step(0, 1, 0, 0);
        chk("all_correct_score", 32'(score), 32'd4);
        chk("all_correct_done", 32'(done), 32'd1);

        // reset while q2 is on screen
        step(1, 0, 0, 0);
        step(0, 1, 0, 0); step(0, 0, 1, mk[0]);
        step(0, 1, 0, 0); step(0, 0, 1, mk[1]);
        step(0, 1, 0, 0);
        chk("mid_show_q_en", 32'(q_en), 32'b0100);
        async_reset();
        chk("reset_q_en", 32'(q_en), 32'd0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("after_reset_q_en", 32'(q_en), 32'b0001);

        // wrong answer, then timeout on q1
        step(0, 0, 1, 8'h00);
        chk("wrong_correct", 32'(result_correct), 32'd0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("timeout_pulse", 32'(timed_out), 32'd1);
        chk("timeout_score", 32'(score), 32'd0);

        // answer on the timeout vsync, then ignored inputs
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, mk[2]);
        chk("simul_to", 32'(timed_out), 32'd0);
        step(0, 0, 0, 0);
        step(0, 0, 1, mk[2]);
        chk("switch_hold_q_en", 32'(q_en), 32'b0100);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, mk[3]);
        step(0, 1, 0, 0);

        // restart with score 3
        step(1, 0, 0, 0);
        step(0, 0, 1, mk[0]);
        for (int i = 0; i < NQ; i++) begin
            step(0, 1, 0, 0);
            step(0, 0, 1, (i == NQ - 1) ? ~mk[i] : mk[i]);
        end
        step(0, 1, 0, 0);
        chk("restart_score_before", 32'(score), 32'd3);
        step(1, 0, 0, 0);
        chk("restart_score", 32'(score), 32'd0);
        step(0, 0, 0, 0);
        chk("restart_q_en_wait", 32'(q_en), 32'd0);
        step(0, 1, 0, 0);
        chk("restart_q_en", 32'(q_en), 32'b0001);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            logic [7:0] a;
            if ((m_idle || m_done) && $urandom_range(0, 3) == 0) begin
                for (int i = 0; i < NQ; i++) mk[i] = 8'($urandom);
                load_keys();
            end
            if ($urandom_range(0, 399) == 0) begin
                async_reset();
            end else begin
                a = ($urandom_range(0, 1) == 1) ? mk[m_q] : 8'($urandom);
                step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0, a);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
